// File: rtl/sha256_msg_schedule.sv
// ============================================================================
// Module   : sha256_msg_schedule
// Purpose  : SHA-256 message schedule; streams W[0..63] from one 512-bit block
//            using a 16-word sliding window, one word per unstalled cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] processedMsg,
    input  logic         beginSchedule,
    input  logic         stall,
    output logic [31:0]  wordOut,
    output logic [5:0]   wordIdx,
    output logic         wordValid,
    output logic         done
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_expand = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [5:0]  t_q, t_d;
    logic [31:0] word_out_q, word_out_d;
    logic [5:0]  word_idx_q, word_idx_d;
    logic        word_valid_q, word_valid_d;
    logic        done_q, done_d;
    logic [31:0] new_word;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign new_word = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        word_out_d   = word_out_q;
        word_idx_d   = word_idx_q;
        word_valid_d = word_valid_q;
        done_d       = done_q;
        for (int i = 0; i < 16; i++) begin
            w_d[i] = w_q[i];
        end

        case (state_q)
            c_st_idle, c_st_done: begin
                if (beginSchedule) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = processedMsg[511 - 32*i -: 32];
                    end
                    t_d          = 6'd0;
                    state_d      = c_st_expand;
                    word_out_d   = processedMsg[511:480];
                    word_idx_d   = 6'd0;
                    word_valid_d = 1'b1;
                    done_d       = 1'b0;
                end
            end
            c_st_expand: begin
                if (!stall) begin
                    if (t_q == 6'd63) begin
                        // Last word already presented: stop without wrapping t.
                        state_d      = c_st_done;
                        word_valid_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            w_d[i] = w_q[i+1];
                        end
                        w_d[15]      = new_word;
                        t_d          = t_q + 6'd1;
                        word_out_d   = w_q[1];
                        word_idx_d   = t_q + 6'd1;
                        word_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d      = c_st_idle;
                word_valid_d = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_st_idle;
            t_q          <= 6'd0;
            word_out_q   <= 32'd0;
            word_idx_q   <= 6'd0;
            word_valid_q <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'd0;
            end
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            word_out_q   <= word_out_d;
            word_idx_q   <= word_idx_d;
            word_valid_q <= word_valid_d;
            done_q       <= done_d;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign wordOut   = word_out_q;
    assign wordIdx   = word_idx_q;
    assign wordValid = word_valid_q;
    assign done      = done_q;

endmodule

`default_nettype wire
